spi_arb_ctrl: RTL and testbench
===============================

SPI_ARB_CTRL -- requirements
Module: spi_arb_ctrl

Interface
REQ-001 Parameters SHALL be: NUM_REQ, default 2, number of requesters; NUM_SS, default 4, number of slave selects; LEN_W, default 4, burst-length field width (burst = len+1 bytes, 1..16).
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk_i  in  1  single clock, all logic on rising edge
- reset_ni  in  1  asynchronous, active-low reset
- req_i  in  NUM_REQ  burst request, level, per requester
- gnt_o  out  NUM_REQ  one-hot, high for the whole granted burst
- cpol_i / cpha_i  in  NUM_REQ each  SPI mode per requester
- dvsr_i  in  NUM_REQ x 16  SCLK divisor per requester
- ss_sel_i  in  NUM_REQ x log2(NUM_SS)  target slave per requester
- len_i  in  NUM_REQ x LEN_W  bytes minus one per requester
- tx_data_i  in  NUM_REQ x 8  next TX byte; tx_valid_i in NUM_REQ; tx_pop_o out NUM_REQ, one-cycle pop
- rx_data_o  out  8  received byte; rx_valid_o out NUM_REQ, one-cycle strobe to owner
- done_o  out  NUM_REQ  one-cycle pulse at end of burst
- busy_o  out  1  high whenever not IDLE
- m_din_o 8, m_dvsr_o 16, m_start_o 1, m_cpol_o 1, m_cpha_o 1  out  drive to SPI master core
- m_ready_i 1, m_done_tick_i 1, m_dout_i 8  in  from SPI master core
- ss_n_o  out  NUM_SS  active-low slave selects

Function
REQ-003 FSM states SHALL be IDLE, SETUP, SS_ON, LOAD, XFER, SS_OFF.
REQ-004 IDLE: when any req_i high, SHALL grant round-robin starting after last-granted index, latch that requester's cpol/cpha/dvsr/ss_sel/len, load byte counter, go SETUP next cycle.
REQ-005 Round-robin SHALL alternate between simultaneous requesters; a lone requester SHALL be regranted back-to-back.
REQ-006 SETUP (1 cycle): m_cpol_o/m_cpha_o/m_dvsr_o SHALL present latched config with all ss_n_o high, so SCLK idle level settles before select.
REQ-007 SS_ON (1 cycle): ss_n_o[latched ss_sel] SHALL go low, held until SS_OFF.
REQ-008 LOAD: when tx_valid_i[owner] and m_ready_i both high, SHALL pulse m_start_o and tx_pop_o[owner] for exactly one cycle with m_din_o = tx_data_i[owner], go XFER; otherwise wait with select held (TX underflow stalls, never aborts).
REQ-009 XFER: on m_din_o held stable; on m_done_tick_i SHALL register m_dout_i to rx_data_o and pulse rx_valid_o[owner] next cycle; if counter = 0 go SS_OFF else decrement, go LOAD.
REQ-010 SS_OFF (1 cycle): all ss_n_o high, done_o[owner] pulsed, gnt_o cleared, return IDLE; no new grant in this cycle.
REQ-011 Config inputs and req_i changes during a burst SHALL be ignored; burst always completes len+1 bytes.
REQ-012 m_start_o SHALL never assert while m_ready_i is low or outside LOAD.
REQ-013 m_done_tick_i outside XFER SHALL be ignored.
REQ-014 At most one ss_n_o bit low at any time; gnt_o, tx_pop_o, rx_valid_o, done_o SHALL be one-hot or zero.

Reset
REQ-015 reset_ni low SHALL immediately force: state IDLE, ss_n_o all ones, gnt_o/tx_pop_o/rx_valid_o/done_o/m_start_o/busy_o 0, rx_data_o/m_din_o 0, m_dvsr_o 0, m_cpol_o/m_cpha_o 0, round-robin pointer so requester 0 wins first.
REQ-016 Reset mid-burst SHALL abort without done_o; first post-reset grant follows REQ-015 pointer.

Structure
REQ-017 Shared package spi_pkg SHALL hold the state enum, spi_cfg_t struct (cpol, cpha, dvsr, ss_sel, len) and default parameters.
REQ-018 Round-robin arbiter SHALL be sub-module spi_rr_arb (req, advance strobe, one-hot grant); rest in spi_arb_ctrl.

Verification
REQ-019 Benches SHALL cover:
- Req0 alone, len=2, dvsr=4, mode 0, ss_sel=1, TX A5,3C,F0, master echo -> three m_start_o pulses, rx A5,3C,F0 to req0, ss_n_o=1101 throughout, one done_o[0].
- req0 and req1 high same cycle, len=0 each -> grants 0 then 1, SS_OFF cycle between, ss_n_o high between bursts.
- tx_valid_i[0] low 20 cycles in LOAD -> no m_start_o, select held low, transfer resumes on valid.
- cpol=1,cpha=1 for req1 after mode-0 burst -> m_cpol_o/m_cpha_o=1 one cycle before ss_n_o falls.
- reset_ni low mid-XFER of byte 2 -> ss_n_o all ones same cycle, no done_o, next grant to req0.
- req0 drops req_i mid-burst, len=3 -> all 4 bytes still transferred.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and default sizing for the SPI arbiter controller.
package spi_pkg;

    localparam int unsigned DEF_NUM_REQ = 2;
    localparam int unsigned DEF_NUM_SS  = 4;
    localparam int unsigned DEF_LEN_W   = 4;
    localparam int unsigned DVSR_W      = 16;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned CFG_SS_W    = $clog2(DEF_NUM_SS);
    localparam int unsigned CFG_LEN_W   = DEF_LEN_W;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SS_ON,
        LOAD,
        XFER,
        SS_OFF
    } state_t;

    // Per-burst configuration captured from the granted requester.
    typedef struct packed {
        logic                 cpol;
        logic                 cpha;
        logic [DVSR_W-1:0]    dvsr;
        logic [CFG_SS_W-1:0]  ss_sel;
        logic [CFG_LEN_W-1:0] len;
    } spi_cfg_t;

endpackage

// File: rtl/spi_arb_ctrl_if.sv
// Requester and SPI-master-core signal bundle for spi_arb_ctrl.
interface spi_arb_ctrl_if
    import spi_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned NUM_SS  = DEF_NUM_SS,
    parameter int unsigned LEN_W   = DEF_LEN_W
);
    localparam int unsigned SS_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;

    logic [NUM_REQ-1:0]             req_i;
    logic [NUM_REQ-1:0]             gnt_o;
    logic [NUM_REQ-1:0]             cpol_i;
    logic [NUM_REQ-1:0]             cpha_i;
    logic [NUM_REQ-1:0][DVSR_W-1:0] dvsr_i;
    logic [NUM_REQ-1:0][SS_W-1:0]   ss_sel_i;
    logic [NUM_REQ-1:0][LEN_W-1:0]  len_i;
    logic [NUM_REQ-1:0][DATA_W-1:0] tx_data_i;
    logic [NUM_REQ-1:0]             tx_valid_i;
    logic [NUM_REQ-1:0]             tx_pop_o;
    logic [DATA_W-1:0]              rx_data_o;
    logic [NUM_REQ-1:0]             rx_valid_o;
    logic [NUM_REQ-1:0]             done_o;
    logic                           busy_o;
    logic [DATA_W-1:0]              m_din_o;
    logic [DVSR_W-1:0]              m_dvsr_o;
    logic                           m_start_o;
    logic                           m_cpol_o;
    logic                           m_cpha_o;
    logic                           m_ready_i;
    logic                           m_done_tick_i;
    logic [DATA_W-1:0]              m_dout_i;
    logic [NUM_SS-1:0]              ss_n_o;

    modport slave (
        input  req_i, cpol_i, cpha_i, dvsr_i, ss_sel_i, len_i, tx_data_i, tx_valid_i,
        input  m_ready_i, m_done_tick_i, m_dout_i,
        output gnt_o, tx_pop_o, rx_data_o, rx_valid_o, done_o, busy_o,
        output m_din_o, m_dvsr_o, m_start_o, m_cpol_o, m_cpha_o, ss_n_o
    );

    modport master (
        output req_i, cpol_i, cpha_i, dvsr_i, ss_sel_i, len_i, tx_data_i, tx_valid_i,
        output m_ready_i, m_done_tick_i, m_dout_i,
        input  gnt_o, tx_pop_o, rx_data_o, rx_valid_o, done_o, busy_o,
        input  m_din_o, m_dvsr_o, m_start_o, m_cpol_o, m_cpha_o, ss_n_o
    );

endinterface

// File: rtl/spi_rr_arb.sv
// Round-robin arbiter: priority starts just above the last granted requester.
module spi_rr_arb #(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] gnt_c
);

    logic [NUM_REQ-1:0] last_q;
    logic [NUM_REQ-1:0] above;
    logic [NUM_REQ-1:0] masked;

    // Pick the lowest request above the last winner, else wrap to the lowest overall.
    always_comb begin
        above  = ~((last_q << 1) - NUM_REQ'(1));
        masked = req & above;
        if (masked != '0) begin
            gnt_c = masked & (~masked + NUM_REQ'(1));
        end else begin
            gnt_c = req & (~req + NUM_REQ'(1));
        end
    end

    // Remember the winner; reset points at the top index so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= NUM_REQ'(1) << (NUM_REQ - 1);
        end else if (advance && (gnt_c != '0)) begin
            last_q <= gnt_c;
        end
    end

endmodule

// File: rtl/spi_arb_ctrl.sv
// Arbitrates SPI master core bursts among several requesters with per-requester mode/select.
module spi_arb_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned NUM_SS  = DEF_NUM_SS,
    parameter int unsigned LEN_W   = DEF_LEN_W
) (
    input  logic           clk_i,
    input  logic           reset_ni,
    spi_arb_ctrl_if.slave  bus
);

    localparam int unsigned SS_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   own_q, own_d, gidx;
    logic [SS_W-1:0]    ss_sel_q, ss_sel_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] rx_valid_q, rx_valid_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               busy_q, busy_d;
    logic [DATA_W-1:0]  rx_data_q, rx_data_d;
    logic [DATA_W-1:0]  din_q, din_d;
    logic [DVSR_W-1:0]  dvsr_q, dvsr_d;
    logic               cpol_q, cpol_d;
    logic               cpha_q, cpha_d;
    logic [NUM_SS-1:0]  ss_n_q, ss_n_d;
    logic [NUM_REQ-1:0] gnt_c;
    logic [NUM_REQ-1:0] tx_pop_c;
    logic               m_start_c;
    logic               advance_c;
    spi_cfg_t           sel_cfg;

    assign advance_c = (state_q == IDLE) && (bus.req_i != '0);

    spi_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk     (clk_i),
        .rst_n   (reset_ni),
        .req     (bus.req_i),
        .advance (advance_c),
        .gnt_c   (gnt_c)
    );

    // Encode the arbiter winner and mux out its configuration.
    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_c[i]) gidx = IDX_W'(i);
        end
        sel_cfg.cpol   = bus.cpol_i[gidx];
        sel_cfg.cpha   = bus.cpha_i[gidx];
        sel_cfg.dvsr   = bus.dvsr_i[gidx];
        sel_cfg.ss_sel = CFG_SS_W'(bus.ss_sel_i[gidx]);
        sel_cfg.len    = CFG_LEN_W'(bus.len_i[gidx]);
    end

    // Next-state and next-output logic; start/pop are same-cycle handshakes with the core.
    always_comb begin
        state_d    = state_q;
        own_d      = own_q;
        ss_sel_d   = ss_sel_q;
        cnt_d      = cnt_q;
        gnt_d      = gnt_q;
        rx_valid_d = '0;
        done_d     = '0;
        rx_data_d  = rx_data_q;
        din_d      = din_q;
        dvsr_d     = dvsr_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        ss_n_d     = ss_n_q;
        tx_pop_c   = '0;
        m_start_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_i != '0) begin
                    state_d  = SETUP;
                    own_d    = gidx;
                    gnt_d    = gnt_c;
                    cnt_d    = LEN_W'(sel_cfg.len);
                    ss_sel_d = SS_W'(sel_cfg.ss_sel);
                    dvsr_d   = sel_cfg.dvsr;
                    cpol_d   = sel_cfg.cpol;
                    cpha_d   = sel_cfg.cpha;
                end
            end
            SETUP: begin
                state_d = SS_ON;
                ss_n_d  = ~(NUM_SS'(1) << ss_sel_q);
            end
            SS_ON: begin
                state_d = LOAD;
            end
            LOAD: begin
                if (bus.tx_valid_i[own_q] && bus.m_ready_i) begin
                    m_start_c       = 1'b1;
                    tx_pop_c[own_q] = 1'b1;
                    din_d           = bus.tx_data_i[own_q];
                    state_d         = XFER;
                end
            end
            XFER: begin
                if (bus.m_done_tick_i) begin
                    rx_data_d         = bus.m_dout_i;
                    rx_valid_d[own_q] = 1'b1;
                    if (cnt_q == '0) begin
                        state_d       = SS_OFF;
                        ss_n_d        = '1;
                        done_d[own_q] = 1'b1;
                        gnt_d         = '0;
                    end else begin
                        cnt_d   = cnt_q - LEN_W'(1);
                        state_d = LOAD;
                    end
                end
            end
            SS_OFF: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset aborts any burst without signalling done.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= IDLE;
            own_q      <= '0;
            ss_sel_q   <= '0;
            cnt_q      <= '0;
            gnt_q      <= '0;
            rx_valid_q <= '0;
            done_q     <= '0;
            busy_q     <= 1'b0;
            rx_data_q  <= '0;
            din_q      <= '0;
            dvsr_q     <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            ss_n_q     <= '1;
        end else begin
            state_q    <= state_d;
            own_q      <= own_d;
            ss_sel_q   <= ss_sel_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            rx_valid_q <= rx_valid_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            rx_data_q  <= rx_data_d;
            din_q      <= din_d;
            dvsr_q     <= dvsr_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            ss_n_q     <= ss_n_d;
        end
    end

    assign bus.gnt_o      = gnt_q;
    assign bus.tx_pop_o   = tx_pop_c;
    assign bus.rx_data_o  = rx_data_q;
    assign bus.rx_valid_o = rx_valid_q;
    assign bus.done_o     = done_q;
    assign bus.busy_o     = busy_q;
    assign bus.m_din_o    = (state_q == LOAD) ? bus.tx_data_i[own_q] : din_q;
    assign bus.m_dvsr_o   = dvsr_q;
    assign bus.m_start_o  = m_start_c;
    assign bus.m_cpol_o   = cpol_q;
    assign bus.m_cpha_o   = cpha_q;
    assign bus.ss_n_o     = ss_n_q;

endmodule

// File: tb/tb_spi_arb_ctrl.sv
// Scoreboard bench for spi_arb_ctrl with an echoing SPI master core model.
module tb_spi_arb_ctrl;

    localparam int LAT = 6;

    typedef struct {
        logic [1:0]  gnt;
        logic        cpol;
        logic        cpha;
        logic [15:0] dvsr;
        logic [3:0]  ss;
    } gexp_t;

    logic clk = 1'b0;
    logic reset_ni;
    logic hold0;
    logic tick_model;
    logic tick_inject;

    spi_arb_ctrl_if sif ();

    spi_arb_ctrl dut (
        .clk_i    (clk),
        .reset_ni (reset_ni),
        .bus      (sif)
    );

    always #5 clk = ~clk;

    assign sif.m_done_tick_i = tick_model | tick_inject;

    int n_checks = 0;
    int n_err    = 0;
    int n_gnt    = 0;
    int n_start  = 0;

    gexp_t      exp_gnt[$];
    logic [7:0] exp_start[$];
    logic [9:0] exp_rx[$];
    logic [1:0] exp_done[$];
    logic [7:0] txq0[$];
    logic [7:0] txq1[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Echo master core plus TX FIFO feeders; acts #1 after each rising edge.
    initial begin : driver
        logic [1:0] pop_seen;
        logic       start_seen;
        logic [7:0] din_seen;
        logic [7:0] mdata;
        int         mcnt;
        mcnt = 0;
        mdata = '0;
        tick_model = 1'b0;
        sif.m_ready_i = 1'b1;
        sif.m_dout_i = '0;
        sif.tx_valid_i = '0;
        sif.tx_data_i = '0;
        forever begin
            @(negedge clk);
            pop_seen   = sif.tx_pop_o;
            start_seen = sif.m_start_o;
            din_seen   = sif.m_din_o;
            @(posedge clk);
            #1;
            if (!reset_ni) begin
                mcnt = 0;
                tick_model = 1'b0;
                sif.m_ready_i = 1'b1;
            end else begin
                if (pop_seen[0] && txq0.size() > 0) txq0.delete(0);
                if (pop_seen[1] && txq1.size() > 0) txq1.delete(0);
                if (tick_model) begin
                    tick_model = 1'b0;
                    sif.m_ready_i = 1'b1;
                end
                if (start_seen) begin
                    sif.m_ready_i = 1'b0;
                    mcnt = LAT;
                    mdata = din_seen;
                end else if (mcnt > 0) begin
                    mcnt--;
                    if (mcnt == 0) begin
                        tick_model = 1'b1;
                        sif.m_dout_i = mdata;
                    end
                end
            end
            sif.tx_valid_i[0] = (txq0.size() > 0) && !hold0;
            sif.tx_data_i[0]  = (txq0.size() > 0) ? txq0[0] : 8'h00;
            sif.tx_valid_i[1] = (txq1.size() > 0);
            sif.tx_data_i[1]  = (txq1.size() > 0) ? txq1[0] : 8'h00;
        end
    end

    // Monitor: pops expectations whenever the DUT presents an event, plus cycle invariants.
    initial begin : monitor
        logic [1:0] gnt_prev;
        logic       busy_prev;
        logic [3:0] cur_ss;
        int         since;
        gexp_t      g;
        logic [7:0] s;
        logic [9:0] r;
        logic [1:0] d;
        gnt_prev = '0;
        busy_prev = 1'b0;
        cur_ss = 4'hF;
        since = 0;
        forever begin
            @(negedge clk);
            if (!reset_ni) begin
                gnt_prev = '0;
                busy_prev = 1'b0;
            end else begin
                check("ss_onehot", 64'($onehot0(~sif.ss_n_o)), 64'd1);
                check("gnt_onehot", 64'($onehot0(sif.gnt_o)), 64'd1);
                check("pop_onehot", 64'($onehot0(sif.tx_pop_o)), 64'd1);
                check("rxv_onehot", 64'($onehot0(sif.rx_valid_o)), 64'd1);
                check("done_onehot", 64'($onehot0(sif.done_o)), 64'd1);
                if (sif.gnt_o != '0 && gnt_prev == '0) begin
                    n_gnt++;
                    if (exp_gnt.size() == 0) begin
                        check("gnt_unexpected", 64'(sif.gnt_o), 64'd0);
                    end else begin
                        g = exp_gnt.pop_front();
                        check("gnt_owner", 64'(sif.gnt_o), 64'(g.gnt));
                        check("setup_cpol", 64'(sif.m_cpol_o), 64'(g.cpol));
                        check("setup_cpha", 64'(sif.m_cpha_o), 64'(g.cpha));
                        check("setup_dvsr", 64'(sif.m_dvsr_o), 64'(g.dvsr));
                        check("setup_ss_high", 64'(sif.ss_n_o), 64'hF);
                        check("idle_before_gnt", 64'({busy_prev, sif.busy_o}), 64'd1);
                        cur_ss = g.ss;
                    end
                    since = 0;
                end else if (sif.gnt_o != '0) begin
                    since++;
                    check("ss_held", 64'(sif.ss_n_o), 64'(cur_ss));
                end else begin
                    check("ss_idle_high", 64'(sif.ss_n_o), 64'hF);
                end
                if (sif.m_start_o) begin
                    n_start++;
                    check("start_cond", 64'({sif.m_ready_i, |(sif.tx_valid_i & sif.gnt_o)}), 64'd3);
                    if (exp_start.size() == 0) begin
                        check("start_unexpected", 64'(sif.m_din_o), 64'hFFFF);
                    end else begin
                        s = exp_start.pop_front();
                        check("start_din", 64'(sif.m_din_o), 64'(s));
                    end
                end
                if (sif.rx_valid_o != '0) begin
                    if (exp_rx.size() == 0) begin
                        check("rx_unexpected", 64'(sif.rx_valid_o), 64'd0);
                    end else begin
                        r = exp_rx.pop_front();
                        check("rx_owner_data", 64'({sif.rx_valid_o, sif.rx_data_o}), 64'(r));
                    end
                end
                if (sif.done_o != '0) begin
                    if (exp_done.size() == 0) begin
                        check("done_unexpected", 64'(sif.done_o), 64'd0);
                    end else begin
                        d = exp_done.pop_front();
                        check("done_owner", 64'(sif.done_o), 64'(d));
                        check("done_gnt_clear", 64'(sif.gnt_o), 64'd0);
                    end
                end
                gnt_prev = sif.gnt_o;
                busy_prev = sif.busy_o;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int r, input logic cpol, input logic cpha, input logic [15:0] dvsr,
                       input logic [1:0] sel, input logic [3:0] len, input logic [3:0] exp_ss);
        gexp_t g;
        sif.cpol_i[r]   = cpol;
        sif.cpha_i[r]   = cpha;
        sif.dvsr_i[r]   = dvsr;
        sif.ss_sel_i[r] = sel;
        sif.len_i[r]    = len;
        g.gnt  = 2'(1 << r);
        g.cpol = cpol;
        g.cpha = cpha;
        g.dvsr = dvsr;
        g.ss   = exp_ss;
        exp_gnt.push_back(g);
        exp_done.push_back(2'(1 << r));
    endtask

    task automatic add_byte(input int r, input logic [7:0] b);
        if (r == 0) txq0.push_back(b);
        else txq1.push_back(b);
        exp_start.push_back(b);
        exp_rx.push_back({2'(1 << r), b});
    endtask

    task automatic wait_grants(input int target);
        int k = 0;
        while (n_gnt < target && k < 500) begin
            cyc(1);
            k++;
        end
        check("grant_wait", 64'(n_gnt >= target), 64'd1);
    endtask

    task automatic wait_quiet();
        int k = 0;
        while ((exp_gnt.size() + exp_start.size() + exp_rx.size() + exp_done.size() != 0
                || sif.busy_o) && k < 3000) begin
            cyc(1);
            k++;
        end
        check("left_gnt", 64'(exp_gnt.size()), 64'd0);
        check("left_start", 64'(exp_start.size()), 64'd0);
        check("left_rx", 64'(exp_rx.size()), 64'd0);
        check("left_done", 64'(exp_done.size()), 64'd0);
        cyc(2);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int s;
        reset_ni = 1'b0;
        hold0 = 1'b0;
        tick_inject = 1'b0;
        sif.req_i = '0;
        sif.cpol_i = '0;
        sif.cpha_i = '0;
        sif.dvsr_i = '0;
        sif.ss_sel_i = '0;
        sif.len_i = '0;
        cyc(3);
        check("rst_ss_n", 64'(sif.ss_n_o), 64'hF);
        check("rst_gnt", 64'(sif.gnt_o), 64'd0);
        check("rst_busy", 64'(sif.busy_o), 64'd0);
        check("rst_start", 64'(sif.m_start_o), 64'd0);
        check("rst_pop", 64'(sif.tx_pop_o), 64'd0);
        check("rst_rxv", 64'(sif.rx_valid_o), 64'd0);
        check("rst_done", 64'(sif.done_o), 64'd0);
        check("rst_rx_data", 64'(sif.rx_data_o), 64'd0);
        check("rst_din", 64'(sif.m_din_o), 64'd0);
        check("rst_dvsr", 64'(sif.m_dvsr_o), 64'd0);
        check("rst_cpol_cpha", 64'({sif.m_cpol_o, sif.m_cpha_o}), 64'd0);
        reset_ni = 1'b1;
        cyc(2);

        // Stray done tick while idle must be ignored.
        tick_inject = 1'b1;
        cyc(1);
        tick_inject = 1'b0;
        cyc(3);

        // Two simultaneous single-byte requests: 0 then 1.
        cfg(0, 1'b0, 1'b0, 16'd4, 2'd2, 4'd0, 4'b1011);
        add_byte(0, 8'h11);
        cfg(1, 1'b0, 1'b0, 16'd4, 2'd3, 4'd0, 4'b0111);
        add_byte(1, 8'h22);
        sif.req_i = 2'b11;
        wait_grants(n_gnt + 1);
        sif.req_i[0] = 1'b0;
        wait_grants(n_gnt + 1);
        sif.req_i[1] = 1'b0;
        wait_quiet();

        // Req0 alone, three bytes, mode 0, select 1.
        cfg(0, 1'b0, 1'b0, 16'd4, 2'd1, 4'd2, 4'b1101);
        add_byte(0, 8'hA5);
        add_byte(0, 8'h3C);
        add_byte(0, 8'hF0);
        sif.req_i[0] = 1'b1;
        wait_grants(n_gnt + 1);
        sif.req_i[0] = 1'b0;
        wait_quiet();

        // Req1 in mode 3 after a mode-0 burst.
        cfg(1, 1'b1, 1'b1, 16'd9, 2'd0, 4'd0, 4'b1110);
        add_byte(1, 8'h5C);
        sif.req_i[1] = 1'b1;
        wait_grants(n_gnt + 1);
        sif.req_i[1] = 1'b0;
        wait_quiet();

        // TX underflow in LOAD stalls with select held; a stray tick there is ignored.
        hold0 = 1'b1;
        cfg(0, 1'b0, 1'b1, 16'd2, 2'd0, 4'd1, 4'b1110);
        add_byte(0, 8'h5A);
        add_byte(0, 8'hC3);
        sif.req_i[0] = 1'b1;
        wait_grants(n_gnt + 1);
        sif.req_i[0] = 1'b0;
        cyc(3);
        s = n_start;
        tick_inject = 1'b1;
        cyc(1);
        tick_inject = 1'b0;
        cyc(19);
        check("stall_no_start", 64'(n_start), 64'(s));
        check("stall_ss_low", 64'(sif.ss_n_o), 64'b1110);
        check("stall_busy", 64'(sif.busy_o), 64'd1);
        hold0 = 1'b0;
        wait_quiet();

        // Req and config dropped mid-burst: all four bytes still go out on the original select.
        cfg(0, 1'b1, 1'b0, 16'd3, 2'd3, 4'd3, 4'b0111);
        add_byte(0, 8'h01);
        add_byte(0, 8'h02);
        add_byte(0, 8'h03);
        add_byte(0, 8'h04);
        sif.req_i[0] = 1'b1;
        wait_grants(n_gnt + 1);
        sif.req_i[0] = 1'b0;
        sif.len_i[0] = 4'd0;
        sif.ss_sel_i[0] = 2'd0;
        sif.cpol_i[0] = 1'b0;
        wait_quiet();

        // Lone requester held high is regranted back-to-back.
        cfg(0, 1'b0, 1'b0, 16'd5, 2'd1, 4'd0, 4'b1101);
        add_byte(0, 8'h77);
        cfg(0, 1'b0, 1'b0, 16'd5, 2'd1, 4'd0, 4'b1101);
        add_byte(0, 8'h88);
        sif.req_i[0] = 1'b1;
        wait_grants(n_gnt + 2);
        sif.req_i[0] = 1'b0;
        wait_quiet();

        // Reset during byte 2 of a req0 burst aborts without done.
        cfg(0, 1'b0, 1'b0, 16'd4, 2'd2, 4'd2, 4'b1011);
        add_byte(0, 8'h10);
        add_byte(0, 8'h20);
        add_byte(0, 8'h30);
        s = n_start;
        sif.req_i[0] = 1'b1;
        wait_grants(n_gnt + 1);
        sif.req_i[0] = 1'b0;
        for (int k = 0; k < 200 && n_start < s + 2; k++) cyc(1);
        check("reach_byte2", 64'(n_start), 64'(s + 2));
        cyc(2);
        reset_ni = 1'b0;
        #1;
        check("abort_ss_n", 64'(sif.ss_n_o), 64'hF);
        check("abort_gnt", 64'(sif.gnt_o), 64'd0);
        check("abort_busy", 64'(sif.busy_o), 64'd0);
        check("abort_done", 64'(sif.done_o), 64'd0);
        check("abort_left_rx", 64'(exp_rx.size()), 64'd2);
        exp_gnt.delete();
        exp_start.delete();
        exp_rx.delete();
        exp_done.delete();
        txq0.delete();
        txq1.delete();
        cyc(3);
        reset_ni = 1'b1;
        cyc(2);
        cfg(0, 1'b0, 1'b0, 16'd6, 2'd1, 4'd0, 4'b1101);
        add_byte(0, 8'h66);
        cfg(1, 1'b0, 1'b0, 16'd6, 2'd2, 4'd0, 4'b1011);
        add_byte(1, 8'h99);
        sif.req_i = 2'b11;
        wait_grants(n_gnt + 1);
        sif.req_i[0] = 1'b0;
        wait_grants(n_gnt + 1);
        sif.req_i[1] = 1'b0;
        wait_quiet();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
